// File: rtl/data_sramlike_wbuf_bridge_if.sv
// rtl/data_sramlike_wbuf_bridge_if.sv - SRAM-like data bus between the bridge and the interconnect
// One outstanding transaction; address and data phases handshake separately.
interface data_sramlike_wbuf_bridge_if #(
  parameter int ADDR_W = 32
);
  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [31:0]       data_wdata;
  logic [31:0]       data_rdata;
  logic              data_addr_ok;
  logic              data_data_ok;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_rdata, data_addr_ok, data_data_ok
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_rdata, data_addr_ok, data_data_ok
  );
endinterface

// File: rtl/data_sramlike_wbuf_bridge.sv
// rtl/data_sramlike_wbuf_bridge.sv - CPU data SRAM port to SRAM-like bus master with posted write buffer
// Stores retire from a FIFO in the background; loads wait for the FIFO and bus to drain.
module data_sramlike_wbuf_bridge #(
  parameter int ADDR_W     = 32,
  parameter int WBUF_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          data_sram_en,
  input  logic [3:0]                    data_sram_wen,
  input  logic [ADDR_W-1:0]             data_sram_addr,
  input  logic [31:0]                   data_sram_wdata,
  output logic [31:0]                   data_sram_rdata,
  output logic                          d_stall,
  input  logic                          longest_stall,
  data_sramlike_wbuf_bridge_if.master   bus,
  output logic [$clog2(WBUF_DEPTH):0]   wbuf_count
);

  localparam int PTR_W = $clog2(WBUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t            state_q, state_d;

  logic [ADDR_W-1:0] fifo_addr_q [WBUF_DEPTH];
  logic [31:0]       fifo_data_q [WBUF_DEPTH];
  logic [1:0]        fifo_size_q [WBUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;

  logic              wr_taken_q, rd_done_q;
  logic              cmd_wr_q, cmd_wr_d;
  logic [1:0]        cmd_size_q, cmd_size_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [31:0]       cmd_wdata_q, cmd_wdata_d;
  logic [31:0]       rdata_q;

  logic              is_store, is_load, full, empty;
  logic              enq, deq, rd_fin, done;
  logic [1:0]        store_size;

  assign is_store = |data_sram_wen;
  assign is_load  = data_sram_en & ~is_store;
  assign full     = (count_q == CNT_W'(WBUF_DEPTH));
  assign empty    = (count_q == '0);
  assign enq      = data_sram_en & is_store & ~wr_taken_q & ~full;

  assign done   = ((state_q == REQ) & bus.data_addr_ok & bus.data_data_ok) |
                  ((state_q == WAIT) & bus.data_data_ok);
  assign deq    = done & cmd_wr_q;
  assign rd_fin = done & ~cmd_wr_q;

  assign d_stall = data_sram_en & ((~is_store & ~rd_done_q) |
                                   (is_store & ~wr_taken_q & ~enq));

  always_comb begin
    case (data_sram_wen)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: store_size = 2'd0;
      4'b0011, 4'b1100:                   store_size = 2'd1;
      default:                            store_size = 2'd2;
    endcase
  end

  // Buffered writes win over a pending load, which keeps loads behind older stores.
  always_comb begin
    state_d     = state_q;
    cmd_wr_d    = cmd_wr_q;
    cmd_size_d  = cmd_size_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          cmd_wr_d    = 1'b1;
          cmd_size_d  = fifo_size_q[rd_ptr_q];
          cmd_addr_d  = fifo_addr_q[rd_ptr_q];
          cmd_wdata_d = fifo_data_q[rd_ptr_q];
          state_d     = REQ;
        end else if (is_load && !rd_done_q) begin
          cmd_wr_d    = 1'b0;
          cmd_size_d  = 2'd2;
          cmd_addr_d  = data_sram_addr;
          cmd_wdata_d = '0;
          state_d     = REQ;
        end
      end
      REQ: begin
        if (bus.data_addr_ok) begin
          state_d = bus.data_data_ok ? IDLE : WAIT;
        end
      end
      WAIT: begin
        if (bus.data_data_ok) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wr_taken_q  <= 1'b0;
      rd_done_q   <= 1'b0;
      cmd_wr_q    <= 1'b0;
      cmd_size_q  <= 2'd0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cmd_wr_q    <= cmd_wr_d;
      cmd_size_q  <= cmd_size_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      // Holding the flag while the stage is stalled stops a held store from re-enqueuing.
      wr_taken_q  <= (enq | wr_taken_q) & longest_stall;
      if (rd_fin) begin
        rd_done_q <= 1'b1;
        rdata_q   <= bus.data_rdata;
      end else if (!longest_stall) begin
        rd_done_q <= 1'b0;
      end
      if (enq) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (deq) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({enq, deq})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_addr_q[wr_ptr_q] <= data_sram_addr;
      fifo_data_q[wr_ptr_q] <= data_sram_wdata;
      fifo_size_q[wr_ptr_q] <= store_size;
    end
  end

  assign bus.data_req   = (state_q == REQ);
  assign bus.data_wr    = cmd_wr_q;
  assign bus.data_size  = cmd_size_q;
  assign bus.data_addr  = cmd_addr_q;
  assign bus.data_wdata = cmd_wdata_q;

  assign data_sram_rdata = rdata_q;
  assign wbuf_count      = count_q;

endmodule

// File: tb/tb_data_sramlike_wbuf_bridge.sv
// tb/tb_data_sramlike_wbuf_bridge.sv - directed and random bench for the data write-buffer bridge
// Expected bus order and load data come from a program-order memory model.
module tb_data_sramlike_wbuf_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        d_stall;
  logic        longest_stall;
  logic        extra_stall;
  logic [2:0]  wbuf_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit        wr;
    bit [1:0]  size;
    bit [31:0] addr;
    bit [31:0] wdata;
  } txn_t;

  txn_t      exp_q[$];
  bit [31:0] model_mem[int];
  bit [31:0] slave_mem[int];

  int addr_lat = 0;
  int data_lat = 1;
  bit pending  = 1'b0;

  always #5 clk = ~clk;

  data_sramlike_wbuf_bridge_if #(.ADDR_W(32)) bus ();

  // A single pipeline stage: it advances whenever nothing stalls it.
  assign longest_stall = d_stall | extra_stall;

  data_sramlike_wbuf_bridge #(.ADDR_W(32), .WBUF_DEPTH(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .d_stall         (d_stall),
    .longest_stall   (longest_stall),
    .bus             (bus),
    .wbuf_count      (wbuf_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit [31:0] dflt(input bit [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic bit [1:0] size_of(input bit [3:0] wen);
    if (wen == 4'b0001 || wen == 4'b0010 || wen == 4'b0100 || wen == 4'b1000) return 2'd0;
    if (wen == 4'b0011 || wen == 4'b1100) return 2'd1;
    return 2'd2;
  endfunction

  // Slave applies writes by bus size and address lanes.
  task automatic slave_complete(input txn_t t);
    int        a;
    bit [31:0] w;
    a = int'(t.addr & 32'hFFFF_FFFC);
    w = slave_mem.exists(a) ? slave_mem[a] : dflt(t.addr & 32'hFFFF_FFFC);
    if (t.wr) begin
      case (t.size)
        2'd0:    w[8*t.addr[1:0] +: 8] = t.wdata[8*t.addr[1:0] +: 8];
        2'd1:    w[16*t.addr[1] +: 16] = t.wdata[16*t.addr[1] +: 16];
        default: w = t.wdata;
      endcase
      slave_mem[a] = w;
    end else begin
      bus.data_rdata = w;
    end
  endtask

  initial begin : slave
    int   req_cnt;
    int   dcnt;
    txn_t cur;
    txn_t e;
    req_cnt = 0;
    dcnt    = 0;
    bus.data_addr_ok = 1'b0;
    bus.data_data_ok = 1'b0;
    bus.data_rdata   = 32'h0;
    forever begin
      @(negedge clk);
      #2;
      bus.data_addr_ok = 1'b0;
      bus.data_data_ok = 1'b0;
      bus.data_rdata   = $urandom;
      if (rst) begin
        pending = 1'b0;
        req_cnt = 0;
      end else begin
        chk("count_bound", {31'b0, wbuf_count > 3'd4}, 32'd0);
        if (pending) begin
          chk("wait_no_req", {31'b0, bus.data_req}, 32'd0);
          dcnt++;
          if (dcnt >= data_lat) begin
            bus.data_data_ok = 1'b1;
            slave_complete(cur);
            pending = 1'b0;
          end
        end else if (bus.data_req) begin
          if (req_cnt >= addr_lat) begin
            req_cnt = 0;
            cur = '{wr: bus.data_wr, size: bus.data_size, addr: bus.data_addr, wdata: bus.data_wdata};
            if (exp_q.size() == 0) begin
              chk("unexpected_txn", 32'd1, 32'd0);
            end else begin
              e = exp_q.pop_front();
              chk("bus_wr", {31'b0, cur.wr}, {31'b0, e.wr});
              chk("bus_size", {30'b0, cur.size}, {30'b0, e.size});
              chk("bus_addr", cur.addr, e.addr);
              if (e.wr) chk("bus_wdata", cur.wdata, e.wdata);
              else chk("rd_after_drain", {29'b0, wbuf_count}, 32'd0);
            end
            bus.data_addr_ok = 1'b1;
            if (data_lat == 0) begin
              bus.data_data_ok = 1'b1;
              slave_complete(cur);
            end else begin
              pending = 1'b1;
              dcnt    = 0;
            end
          end else begin
            req_cnt++;
          end
        end
      end
    end
  end

  // Presents one access and returns once the stage advances past it.
  task automatic cpu_op(input bit [3:0] wen, input bit [31:0] addr, input bit [31:0] wdata,
                        output int stalls);
    bit        st;
    bit [31:0] w;
    int        a;
    a = int'(addr & 32'hFFFF_FFFC);
    w = model_mem.exists(a) ? model_mem[a] : dflt(addr & 32'hFFFF_FFFC);
    if (wen != 4'b0) begin
      exp_q.push_back('{wr: 1'b1, size: size_of(wen), addr: addr, wdata: wdata});
      for (int i = 0; i < 4; i++) if (wen[i]) w[8*i +: 8] = wdata[8*i +: 8];
      model_mem[a] = w;
    end else begin
      exp_q.push_back('{wr: 1'b0, size: 2'd2, addr: addr, wdata: 32'h0});
    end
    @(negedge clk);
    data_sram_en    = 1'b1;
    data_sram_wen   = wen;
    data_sram_addr  = addr;
    data_sram_wdata = wdata;
    stalls = 0;
    forever begin
      #1;
      st = longest_stall;
      @(posedge clk);
      if (!st) break;
      stalls++;
      if (stalls > 2000) begin
        chk("cpu_timeout", 32'd1, 32'd0);
        break;
      end
      @(negedge clk);
    end
    #1;
    data_sram_en = 1'b0;
    if (wen == 4'b0) chk("load_data", data_sram_rdata, w);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((wbuf_count != 0 || bus.data_req || pending || exp_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      #3;
      n++;
    end
    chk("drain_timeout", {31'b0, n >= 3000}, 32'd0);
  endtask

  initial begin : main
    int        st;
    bit [31:0] held;
    bit [1:0]  sz;
    bit [1:0]  off;
    bit [3:0]  wen;
    bit [31:0] a;
    int        n;
    rst = 1'b1;
    extra_stall = 1'b0;
    data_sram_en = 1'b0;
    data_sram_wen = 4'b0;
    data_sram_addr = 32'h0;
    data_sram_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", {31'b0, bus.data_req}, 32'd0);
    chk("rst_wr", {31'b0, bus.data_wr}, 32'd0);
    chk("rst_size", {30'b0, bus.data_size}, 32'd0);
    chk("rst_addr", bus.data_addr, 32'd0);
    chk("rst_wdata", bus.data_wdata, 32'd0);
    chk("rst_rdata", data_sram_rdata, 32'd0);
    chk("rst_count", {29'b0, wbuf_count}, 32'd0);
    chk("rst_dstall", {31'b0, d_stall}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single load with one cycle from addr_ok to data_ok.
    slave_mem[32'h1000] = 32'hDEAD_BEEF;
    model_mem[32'h1000] = 32'hDEAD_BEEF;
    addr_lat = 0;
    data_lat = 1;
    cpu_op(4'b0000, 32'h1000, 32'h0, st);
    chk("load_stall_cycles", st, 32'd3);
    repeat (3) @(negedge clk);
    chk("load_rdata_held", data_sram_rdata, 32'hDEAD_BEEF);
    drain();

    // Four posted stores fill the buffer; the fifth waits for the first retirement.
    addr_lat = 5;
    cpu_op(4'b0001, 32'h200, 32'h1111_1111, st);
    chk("st0_stall", st, 32'd0);
    cpu_op(4'b0011, 32'h204, 32'h2222_2222, st);
    chk("st1_stall", st, 32'd0);
    cpu_op(4'b1111, 32'h208, 32'h3333_3333, st);
    chk("st2_stall", st, 32'd0);
    cpu_op(4'b1100, 32'h20E, 32'h4444_4444, st);
    chk("st3_stall", st, 32'd0);
    chk("full_count", {29'b0, wbuf_count}, 32'd4);
    cpu_op(4'b1111, 32'h210, 32'h5555_5555, st);
    chk("st4_full_stall", st, 32'd5);
    drain();
    addr_lat = 0;
    cpu_op(4'b0000, 32'h20C, 32'h0, st);
    cpu_op(4'b0000, 32'h200, 32'h0, st);
    drain();

    // Read after write to the same address.
    addr_lat = 2;
    data_lat = 2;
    cpu_op(4'b1111, 32'h20, 32'hCAFE_F00D, st);
    cpu_op(4'b0000, 32'h20, 32'h0, st);
    chk("raw_rdata", data_sram_rdata, 32'hCAFE_F00D);
    drain();

    // Address and data handshake in the same cycle.
    addr_lat = 0;
    data_lat = 0;
    cpu_op(4'b0000, 32'h1000, 32'h0, st);
    chk("sameclk_stall_cycles", st, 32'd2);
    drain();

    // Store held by a pipeline stall is enqueued exactly once.
    addr_lat = 1000;
    data_lat = 1;
    exp_q.push_back('{wr: 1'b1, size: 2'd2, addr: 32'h40, wdata: 32'h0BAD_F00D});
    model_mem[32'h40] = 32'h0BAD_F00D;
    @(negedge clk);
    data_sram_en = 1'b1;
    data_sram_wen = 4'b1111;
    data_sram_addr = 32'h40;
    data_sram_wdata = 32'h0BAD_F00D;
    extra_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("hold_dstall", {31'b0, d_stall}, 32'd0);
      @(posedge clk);
      #1;
      chk("hold_count", {29'b0, wbuf_count}, 32'd1);
      @(negedge clk);
    end
    extra_stall = 1'b0;
    @(posedge clk);
    #1;
    data_sram_en = 1'b0;
    chk("hold_release_count", {29'b0, wbuf_count}, 32'd1);
    cpu_op(4'b1111, 32'h44, 32'h1234_5678, st);
    chk("after_hold_stall", st, 32'd0);
    chk("after_hold_count", {29'b0, wbuf_count}, 32'd2);
    addr_lat = 0;
    drain();

    // Reset while a write sits in the data phase.
    data_lat = 1000;
    cpu_op(4'b1111, 32'h80, 32'hFFFF_0000, st);
    n = 0;
    while (!pending && n < 50) begin
      @(negedge clk);
      #3;
      n++;
    end
    chk("reach_wait", {31'b0, pending}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    data_sram_en = 1'b1;
    data_sram_wen = 4'b0000;
    data_sram_addr = 32'h80;
    @(posedge clk);
    #1;
    chk("midrst_req", {31'b0, bus.data_req}, 32'd0);
    chk("midrst_count", {29'b0, wbuf_count}, 32'd0);
    chk("midrst_rdata", data_sram_rdata, 32'd0);
    chk("midrst_dstall", {31'b0, d_stall}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    data_sram_en = 1'b0;
    exp_q.delete();
    model_mem.delete();
    slave_mem.delete();
    data_lat = 1;
    repeat (2) @(negedge clk);

    // Random mix against the program-order model.
    for (int k = 0; k < 80; k++) begin
      addr_lat = $urandom_range(0, 3);
      data_lat = $urandom_range(0, 3);
      a = 32'h300 + 4 * $urandom_range(0, 7);
      if ($urandom_range(0, 1) == 1) begin
        sz  = 2'($urandom_range(0, 2));
        off = 2'($urandom_range(0, 3));
        case (sz)
          2'd0:    begin wen = 4'b0001 << off; a = a + {30'b0, off}; end
          2'd1:    begin wen = off[1] ? 4'b1100 : 4'b0011; a = a + (off[1] ? 32'd2 : 32'd0); end
          default: wen = 4'b1111;
        endcase
        cpu_op(wen, a, $urandom, st);
      end else begin
        cpu_op(4'b0000, a, 32'h0, st);
      end
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
